// File: rtl/cgra_mem_pkg.sv
// Shared definitions for the CGRA data memory.
//   - mem_state_e : controller state (hardware clear, then normal operation)
//   - DEF_*       : default configuration of the memory
//   - slice_lo    : low bit index of channel 'ch' in a flattened per-channel bus
//   - is_pow2     : elaboration-time check on the depth parameter
package cgra_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_e;

    localparam int DEF_NPORTS = 3;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 64;

    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cgra_mem_wr_arb.sv
// Store arbitration for the CGRA data memory (purely combinational).
// When several enabled stores target the same address in one cycle, the
// lowest channel index wins; every other channel on that address loses.
// Ports:
//   st_en_i    [NPORTS]      store requests (already gated by the caller)
//   st_addr_i  [NPORTS*AW]   store addresses, channel i at [i*AW +: AW]
//   commit_o   [NPORTS]      store of channel i is written this cycle
//   conflict_o [NPORTS]      store of channel i is dropped this cycle
module cgra_mem_wr_arb
    import cgra_mem_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int AW     = 6
) (
    input  logic [NPORTS-1:0]    st_en_i,
    input  logic [NPORTS*AW-1:0] st_addr_i,
    output logic [NPORTS-1:0]    commit_o,
    output logic [NPORTS-1:0]    conflict_o
);

    genvar gi;
    for (gi = 0; gi < NPORTS; gi++) begin : g_ch
        logic lost;

        // A channel loses if any lower-indexed enabled channel has the same address.
        always_comb begin
            lost = 1'b0;
            for (int j = 0; j < gi; j++) begin
                if (st_en_i[gi] && st_en_i[j] &&
                    (st_addr_i[slice_lo(gi, AW) +: AW] == st_addr_i[slice_lo(j, AW) +: AW])) begin
                    lost = 1'b1;
                end
            end
        end

        assign commit_o[gi]   = st_en_i[gi] & ~lost;
        assign conflict_o[gi] = lost;
    end

endmodule

// File: rtl/cgra_data_mem.sv
// Multi-port data memory for the CGRA load/store buses.
// After reset the memory zeroes itself (one word per cycle, DEPTH cycles);
// requests are ignored until 'ready' is high.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   ld_en/ld_addr               per-channel load requests
//   ld_data/ld_valid            registered load results (1-cycle latency)
//   st_en/st_addr/st_data       per-channel store requests
//   st_conflict                 registered pulse: channel's store was dropped
//   ready                       clear sequence complete
// Build option: define CGRA_MEM_FWD_EN to forward same-cycle store data to
// loads at the same address (write-before-read). Undefined: read-before-write.
module cgra_data_mem
    import cgra_mem_pkg::*;
#(
    parameter int  NPORTS = DEF_NPORTS,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NPORTS-1:0]        ld_en,
    input  logic [NPORTS*AW-1:0]     ld_addr,
    output logic [NPORTS*DATA_W-1:0] ld_data,
    output logic [NPORTS-1:0]        ld_valid,
    input  logic [NPORTS-1:0]        st_en,
    input  logic [NPORTS*AW-1:0]     st_addr,
    input  logic [NPORTS*DATA_W-1:0] st_data,
    output logic [NPORTS-1:0]        st_conflict,
    output logic                     ready
);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("cgra_data_mem: DEPTH must be a power of two >= 2");
    end
    if (NPORTS < 1 || NPORTS > 8) begin : g_bad_nports
        $error("cgra_data_mem: NPORTS must be in 1..8");
    end

    mem_state_e  state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ld_data_q [NPORTS];
    logic              ld_valid_q [NPORTS];
    logic [NPORTS-1:0] st_conflict_q;

    logic              accept;
    logic [NPORTS-1:0] commit;
    logic [NPORTS-1:0] conflict;

    // Requests count only in RUN and never on a reset edge.
    assign accept = (state_q == RUN) && !RST;
    assign ready  = (state_q == RUN);

    // Clear sequencer
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    cgra_mem_wr_arb #(
        .NPORTS (NPORTS),
        .AW     (AW)
    ) u_wr_arb (
        .st_en_i    (st_en & {NPORTS{accept}}),
        .st_addr_i  (st_addr),
        .commit_o   (commit),
        .conflict_o (conflict)
    );

    // Storage: no reset so the array maps onto block RAM; the clear
    // sequence provides the zero state instead. Committed stores never
    // share an address, so the write order inside the loop is irrelevant.
    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (commit[j]) begin
                    mem_q[st_addr[slice_lo(j, AW) +: AW]] <= st_data[slice_lo(j, DATA_W) +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_conflict_q <= '0;
        end else begin
            st_conflict_q <= conflict;
        end
    end

    assign st_conflict = st_conflict_q;

    genvar gi;
    for (gi = 0; gi < NPORTS; gi++) begin : g_ld
        logic [AW-1:0] rd_addr;
        assign rd_addr = ld_addr[slice_lo(gi, AW) +: AW];

`ifdef CGRA_MEM_FWD_EN
        // At most one committed store per address, so the first hit is the winner.
        logic              fwd_hit;
        logic [DATA_W-1:0] fwd_data;
        always_comb begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
            for (int j = 0; j < NPORTS; j++) begin
                if (commit[j] && (st_addr[slice_lo(j, AW) +: AW] == rd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = st_data[slice_lo(j, DATA_W) +: DATA_W];
                end
            end
        end
`endif

        always_ff @(posedge CLK) begin
            if (RST) begin
                ld_data_q[gi]  <= '0;
                ld_valid_q[gi] <= 1'b0;
            end else begin
                ld_valid_q[gi] <= accept && ld_en[gi];
                if (accept && ld_en[gi]) begin
`ifdef CGRA_MEM_FWD_EN
                    ld_data_q[gi] <= fwd_hit ? fwd_data : mem_q[rd_addr];
`else
                    ld_data_q[gi] <= mem_q[rd_addr];
`endif
                end
            end
        end

        assign ld_data[slice_lo(gi, DATA_W) +: DATA_W] = ld_data_q[gi];
        assign ld_valid[gi]                            = ld_valid_q[gi];
    end

endmodule
